// File: rtl/exec_pkg.sv
// Shared encodings for the RV32 execute stage: ALU ops, branch conditions and
// forwarding selects.
package exec_pkg;

  localparam int LINK_OFFSET = 4;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_MUL   = 4'b1010,
    ALU_PASSB = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RDX = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/iter_mul.sv
// Shift-add multiplier, one partial product per cycle, low W bits of the product.
// p is valid combinationally in the done cycle (it already includes the last partial).
module iter_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] p
);
  localparam int CW = $clog2(W + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W-1:0]  pp;

  assign pp   = b_q[0] ? a_q : '0;
  assign p    = acc_q + pp;
  assign busy = busy_q;
  assign done = busy_q & (cnt_q == CW'(1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CW'(W);
        a_d    = a;
        b_d    = b;
        acc_d  = '0;
      end
    end else begin
      acc_d = p;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// RV32 execute stage: forwarding, ALU, branch/jump resolution, iterative MUL
// and the EX/MEM pipeline register.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_E,
  input  logic                  flush_E,
  input  logic                  ALUsrc,
  input  logic [3:0]            ALUctrl,
  input  logic [2:0]            funct3_E,
  input  logic                  jump_E,
  input  logic                  jalr_E,
  input  logic                  branch_E,
  input  logic [1:0]            fwdA_E,
  input  logic [1:0]            fwdB_E,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic [DATA_WIDTH-1:0] PC_E,
  input  logic [DATA_WIDTH-1:0] Result_W,
  output logic [DATA_WIDTH-1:0] ALUout_M,
  output logic [DATA_WIDTH-1:0] WriteData_M,
  output logic                  valid_M,
  output logic                  PCsrc_E,
  output logic [DATA_WIDTH-1:0] PCtarget_E,
  output logic                  stall_E
);
  localparam int SW = $clog2(DATA_WIDTH);

  alu_op_e               op;
  logic [DATA_WIDTH-1:0] a_op, bsrc_op, b_op, alu_res, link_addr, jalr_sum;
  logic [SW-1:0]         shamt;
  logic                  br_cond, is_mul;
  logic                  mul_start, mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_p;
  logic [DATA_WIDTH-1:0] alu_m_q, alu_m_d, wd_m_q, wd_m_d;
  logic                  valid_m_q, valid_m_d;

  assign op     = alu_op_e'(ALUctrl);
  assign is_mul = MUL_EN && (op == ALU_MUL);
  assign shamt  = b_op[SW-1:0];

  always_comb begin
    unique case (fwd_sel_e'(fwdA_E))
      FWD_WB:  a_op = Result_W;
      FWD_MEM: a_op = alu_m_q;
      default: a_op = RD1;
    endcase
    unique case (fwd_sel_e'(fwdB_E))
      FWD_WB:  bsrc_op = Result_W;
      FWD_MEM: bsrc_op = alu_m_q;
      default: bsrc_op = RD2;
    endcase
    b_op = ALUsrc ? ImmOp : bsrc_op;
  end

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:   alu_res = a_op + b_op;
      ALU_SUB:   alu_res = a_op - b_op;
      ALU_AND:   alu_res = a_op & b_op;
      ALU_OR:    alu_res = a_op | b_op;
      ALU_XOR:   alu_res = a_op ^ b_op;
      ALU_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a_op) < $signed(b_op)};
      ALU_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, a_op < b_op};
      ALU_SLL:   alu_res = a_op << shamt;
      ALU_SRL:   alu_res = a_op >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(a_op) >>> shamt);
      ALU_MUL:   alu_res = MUL_EN ? mul_p : a_op + b_op;
      ALU_PASSB: alu_res = b_op;
      default:   alu_res = '0;
    endcase
  end

  // Branches compare the forwarded register values, never the immediate.
  always_comb begin
    case (br_cond_e'(funct3_E))
      BR_EQ:   br_cond = (a_op == bsrc_op);
      BR_NE:   br_cond = (a_op != bsrc_op);
      BR_LT:   br_cond = ($signed(a_op) < $signed(bsrc_op));
      BR_GE:   br_cond = ($signed(a_op) >= $signed(bsrc_op));
      BR_LTU:  br_cond = (a_op < bsrc_op);
      BR_GEU:  br_cond = (a_op >= bsrc_op);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum   = a_op + ImmOp;
  assign link_addr  = PC_E + DATA_WIDTH'(LINK_OFFSET);
  assign PCtarget_E = jalr_E ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : PC_E + ImmOp;
  assign PCsrc_E    = ~rst & valid_E & ~flush_E & ~is_mul & (jump_E | (branch_E & br_cond));

  assign mul_start = valid_E & is_mul & ~flush_E & ~mul_busy;
  assign stall_E   = ~rst & (mul_start | (mul_busy & ~mul_done));

  generate
    if (MUL_EN) begin : g_mul
      iter_mul #(.W(DATA_WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(mul_start),
        .abort(flush_E),
        .a    (a_op),
        .b    (b_op),
        .busy (mul_busy),
        .done (mul_done),
        .p    (mul_p)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_p    = '0;
    end
  endgenerate

  // A stalled cycle emits a bubble and keeps the last data values.
  always_comb begin
    alu_m_d   = alu_m_q;
    wd_m_d    = wd_m_q;
    valid_m_d = 1'b0;
    if (!stall_E) begin
      alu_m_d   = jump_E ? link_addr : alu_res;
      wd_m_d    = bsrc_op;
      valid_m_d = valid_E & ~flush_E;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_m_q   <= '0;
      wd_m_q    <= '0;
      valid_m_q <= 1'b0;
    end else begin
      alu_m_q   <= alu_m_d;
      wd_m_q    <= wd_m_d;
      valid_m_q <= valid_m_d;
    end
  end

  assign ALUout_M    = alu_m_q;
  assign WriteData_M = wd_m_q;
  assign valid_M     = valid_m_q;

endmodule
